// File: rtl/apb_master_arbiter_if.sv
// Bundles the requester-side handshake and the APB bus of the multi-requester APB master.
// A request is accepted on the rising edge where req_valid[i] and req_ready[i] are both high;
// req_* stay stable while req_valid is high and req_ready is low, and rsp_valid is a one-cycle pulse.
interface apb_master_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;
    logic                          PSELx;
    logic                          PENABLE;
    logic                          PWRITE;
    logic [ADDR_WIDTH-1:0]         PADDR;
    logic [DATA_WIDTH-1:0]         PWDATA;
    logic [DATA_WIDTH-1:0]         PRDATA;
    logic                          PREADY;
    logic                          PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ local requesters onto one APB bus,
// sequencing SETUP/ACCESS, absorbing wait states and aborting stalled transfers.
module apb_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic               Pclk,
    input  logic               Prst,
    apb_master_arbiter_if.master bus,
    output logic [1:0]         fsm_state
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       idx_q;
    logic [CW-1:0]       cnt_q;
    logic [IW-1:0]       win_idx;
    logic                any_req;
    logic                take;
    logic                done;
    logic                abort;
    logic [NUM_REQ-1:0]  grant;

    // Scan offsets from the highest down so the lowest offset from the pointer wins.
    always_comb begin
        int j;
        any_req = 1'b0;
        win_idx = '0;
        j       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (bus.req_valid[j]) begin
                any_req = 1'b1;
                win_idx = IW'(j);
            end
        end
    end

    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // PREADY on the final allowed cycle wins over the timeout abort.
    always_comb begin
        state_d = state_q;
        grant   = '0;
        take    = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req && !Prst) begin
                    take           = 1'b1;
                    grant[win_idx] = 1'b1;
                    state_d        = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (bus.PREADY) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = grant;
    assign bus.PSELx     = (state_q != IDLE);
    assign bus.PENABLE   = (state_q == ACCESS);
    assign fsm_state     = state_q;

    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) begin
            ptr_q         <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= '0;
            if (take) begin
                bus.PWRITE <= bus.req_write[win_idx];
                bus.PADDR  <= bus.req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                bus.PWDATA <= bus.req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                idx_q      <= win_idx;
                ptr_q      <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
                cnt_q      <= '0;
            end
            if (done) begin
                bus.rsp_valid[idx_q] <= 1'b1;
                bus.rsp_rdata        <= bus.PWRITE ? '0 : bus.PRDATA;
                bus.rsp_err          <= bus.PSLVERR;
            end else if (abort) begin
                bus.rsp_valid[idx_q] <= 1'b1;
                bus.rsp_rdata        <= '0;
                bus.rsp_err          <= 1'b1;
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Multi-requester APB master: arbitrates NUM_REQ local requesters onto one APB bus using round-robin.
- Sequences the APB SETUP/ACCESS phases and absorbs PREADY wait states.
- Returns read data, error and completion status to the granted requester.
- Bounds each transfer with a timeout counter.
- Sits between the test/system requesters and the APB slave interface (Pclk domain).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 8, PADDR width
DATA_WIDTH, 8, PWDATA/PRDATA width
TIMEOUT, 16, max ACCESS cycles with PREADY low before abort (>=1)

Ports:
Pclk  in  1  APB clock, rising edge
Prst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester transfer request, held until req_ready
req_ready  out  NUM_REQ  one-hot grant/accept; command captured on the edge it is high
req_write  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same packing
rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_err  out  1  PSLVERR or timeout, valid with rsp_valid
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset (Prst=1, async): state=IDLE. All outputs 0. RR pointer=0. Timeout counter=0.
- Reset mid-transfer: the in-flight transfer is dropped; no rsp_valid is generated for it.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid, assert req_ready for the winner only (combinational from state, pointer, req_valid).
  - Winner = first asserted req_valid at or after the pointer, wrapping modulo NUM_REQ.
  - On that edge: latch write/addr/wdata into PWRITE/PADDR/PWDATA, record the grant index, set pointer=(index+1) mod NUM_REQ, go to SETUP.
  - No request: stay in IDLE; pointer unchanged.
- SETUP (1 cycle): PSELx=1, PENABLE=0, then go to ACCESS.
- ACCESS: PSELx=1, PENABLE=1.
  - PREADY=1: capture PRDATA into rsp_rdata (0 for writes) and PSLVERR into rsp_err. Next cycle rsp_valid[index]=1 for exactly one cycle. Go to IDLE.
  - PREADY=0: increment the timeout counter.
  - Timeout: if the counter reaches TIMEOUT with PREADY still low, abort. Next cycle rsp_valid[index]=1, rsp_err=1, rsp_rdata=0; PSELx/PENABLE drop to 0; go to IDLE.
  - The counter clears on every entry to SETUP.
- Address/control stability: PWRITE/PADDR/PWDATA are stable from SETUP through the end of ACCESS. In IDLE they hold their last values.
- PSELx and PENABLE are 0 in IDLE.
- Throughput:
  - Minimum 3 cycles per transfer (IDLE grant, SETUP, ACCESS with PREADY=1).
  - The rsp_valid pulse overlaps the next IDLE/grant cycle.
  - A requester whose rsp_valid is high may be regranted in that same cycle only if no other requester is valid.
- rsp_rdata/rsp_err hold their values until the next completion. rsp_valid is 0 except for the completion pulse.
- Requester contract: req_* must stay stable while req_valid=1 and req_ready=0. Deasserting req_valid before grant is allowed; the request is then simply not served.
- PREADY and PSLVERR are ignored outside ACCESS.
- A PSLVERR with PREADY=1 on the timeout-boundary cycle counts as a normal completion with rsp_err=PSLVERR, not a timeout.

Test Plan:
- Reset then req 0 write addr 0x1A data 0x5C, PREADY tied 1 -> req_ready[0] in cycle 0; SETUP cycle 1 (PSELx=1, PENABLE=0, PADDR=0x1A, PWDATA=0x5C, PWRITE=1); ACCESS cycle 2; rsp_valid[0] in cycle 3 with rsp_err=0.
- Req 2 read addr 0x33, PREADY low 2 ACCESS cycles, PRDATA=0xA7 when PREADY high -> PADDR stable over all ACCESS cycles; rsp_valid[2]=1, rsp_rdata=0xA7, rsp_err=0.
- All 4 requesters continuously valid from reset -> grant order 0,1,2,3,0,1; each grant 3 cycles apart with zero-wait PREADY.
- PREADY held 0 forever, TIMEOUT=16 -> exactly 16 ACCESS cycles; then rsp_valid pulse with rsp_err=1, rsp_rdata=0, PSELx=0, and the next request is serviced normally.
- Req 1 read with PSLVERR=1, PREADY=1 in the first ACCESS cycle -> rsp_valid[1]=1, rsp_err=1; the next transfer from req 1 reports rsp_err=0.
- Prst asserted during ACCESS (PREADY low), released 2 cycles later -> all outputs 0 immediately (async); no rsp_valid; pointer=0, so req 0 wins when requesters 0 and 3 are both valid.
